// File: rtl/fifo_16x32_sync.sv
// 16-entry x 32-bit synchronous FIFO with first-word fall-through read,
// threshold flags and sticky overflow/underflow error flags.
module fifo_16x32_sync #(
  parameter int unsigned ALMOST_FULL_LEVEL  = 12,
  parameter int unsigned ALMOST_EMPTY_LEVEL = 2
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        flush,
  input  logic        pushValid,
  input  logic [31:0] pushData,
  output logic        pushReady,
  output logic        popValid,
  output logic [31:0] popData,
  input  logic        popReady,
  output logic [4:0]  count,
  output logic        almostFull,
  output logic        almostEmpty,
  output logic        overflow,
  output logic        underflow
);

  logic [31:0] mem [16];
  logic [4:0]  writePtr;
  logic [4:0]  readPtr;
  logic        full;
  logic        empty;
  logic        doPush;
  logic        doPop;

  // Address bits equal with differing wrap bit means the write side lapped the read side.
  always_comb begin
    empty = (writePtr == readPtr);
    full  = (writePtr[3:0] == readPtr[3:0]) && (writePtr[4] != readPtr[4]);
  end

  always_comb begin
    pushReady   = !full;
    popValid    = !empty;
    popData     = mem[readPtr[3:0]];
    doPush      = pushValid && !full && !flush;
    doPop       = popReady && !empty && !flush;
    almostFull  = (32'(count) >= ALMOST_FULL_LEVEL);
    almostEmpty = (32'(count) <= ALMOST_EMPTY_LEVEL);
  end

  // Storage is never cleared; reset only makes old entries unreachable.
  always_ff @(posedge clock) begin
    if (resetN && doPush) begin
      mem[writePtr[3:0]] <= pushData;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN || flush) begin
      writePtr  <= 5'd0;
      readPtr   <= 5'd0;
      count     <= 5'd0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (doPush) begin
        writePtr <= writePtr + 5'd1;
      end
      if (doPop) begin
        readPtr <= readPtr + 5'd1;
      end
      unique case ({doPush, doPop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      if (pushValid && full) begin
        overflow <= 1'b1;
      end
      if (popReady && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_16x32_sync.sv
// Self-checking bench for fifo_16x32_sync: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_fifo_16x32_sync;

  localparam int unsigned AfLevel = 12;
  localparam int unsigned AeLevel = 2;

  logic        clock;
  logic        resetN;
  logic        flush;
  logic        pushValid;
  logic [31:0] pushData;
  logic        pushReady;
  logic        popValid;
  logic [31:0] popData;
  logic        popReady;
  logic [4:0]  count;
  logic        almostFull;
  logic        almostEmpty;
  logic        overflow;
  logic        underflow;

  fifo_16x32_sync #(
    .ALMOST_FULL_LEVEL (AfLevel),
    .ALMOST_EMPTY_LEVEL(AeLevel)
  ) dut (
    .clock      (clock),
    .resetN     (resetN),
    .flush      (flush),
    .pushValid  (pushValid),
    .pushData   (pushData),
    .pushReady  (pushReady),
    .popValid   (popValid),
    .popData    (popData),
    .popReady   (popReady),
    .count      (count),
    .almostFull (almostFull),
    .almostEmpty(almostEmpty),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nCompared = 0;
  int nFail     = 0;

  // Reference model: plain queue plus sticky flags.
  logic [31:0] modelQ[$];
  bit          modelOvf;
  bit          modelUdf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int sz;
    sz = modelQ.size();
    if (!resetN || flush) begin
      modelQ.delete();
      modelOvf = 1'b0;
      modelUdf = 1'b0;
    end else begin
      if (pushValid && sz == 16) modelOvf = 1'b1;
      if (popReady && sz == 0) modelUdf = 1'b1;
      if (popReady && sz > 0) void'(modelQ.pop_front());
      if (pushValid && sz < 16) modelQ.push_back(pushData);
    end
  endtask

  task automatic model_check();
    int sz;
    sz = modelQ.size();
    check("count", 32'(count), 32'(sz));
    check("pushReady", 32'(pushReady), 32'(sz < 16));
    check("popValid", 32'(popValid), 32'(sz > 0));
    if (sz > 0) check("popData", popData, modelQ[0]);
    check("almostFull", 32'(almostFull), 32'(sz >= int'(AfLevel)));
    check("almostEmpty", 32'(almostEmpty), 32'(sz <= int'(AeLevel)));
    check("overflow", 32'(overflow), 32'(modelOvf));
    check("underflow", 32'(underflow), 32'(modelUdf));
  endtask

  // One clock: inputs already stable, model follows the edge, outputs sampled #1 later.
  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    model_check();
  endtask

  task automatic drive(input bit r, input bit f, input bit pv, input logic [31:0] pd,
                       input bit pr);
    resetN    = r;
    flush     = f;
    pushValid = pv;
    pushData  = pd;
    popReady  = pr;
  endtask

  task automatic idle_cycle();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle();
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle();
  endtask

  typedef struct {
    bit          rstN;
    bit          fl;
    bit          pv;
    logic [31:0] pd;
    bit          pr;
    logic [4:0]  expCount;
    bit          expPopValid;
    logic [31:0] expPopData;
    bit          expOvf;
    bit          expUdf;
  } vec_t;

  vec_t vecs[9];

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;

    // Vector table, starting from reset; expected values are post-edge outputs.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 5'd0, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'hA1A1A1A1, 1'b0, 5'd1, 1'b1, 32'hA1A1A1A1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 32'hA2A2A2A2, 1'b1, 5'd1, 1'b1, 32'hA2A2A2A2, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'hFFFF0000, 1'b1, 5'd0, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'hB1B1B1B1, 1'b1, 5'd1, 1'b1, 32'hB1B1B1B1, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 5'd1, 1'b1, 32'hB1B1B1B1, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 5'd0, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 32'h12345678, 1'b1, 5'd0, 1'b0, 32'h0,        1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].rstN, vecs[i].fl, vecs[i].pv, vecs[i].pd, vecs[i].pr);
      cycle();
      check($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].expCount));
      check($sformatf("vec%0d.popValid", i), 32'(popValid), 32'(vecs[i].expPopValid));
      if (vecs[i].expPopValid) check($sformatf("vec%0d.popData", i), popData, vecs[i].expPopData);
      check($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(vecs[i].expOvf));
      check($sformatf("vec%0d.underflow", i), 32'(underflow), 32'(vecs[i].expUdf));
    end

    // Reset outputs.
    do_reset();
    check("rst.pushReady", 32'(pushReady), 32'd1);
    check("rst.almostEmpty", 32'(almostEmpty), 32'd1);
    check("rst.almostFull", 32'(almostFull), 32'd0);

    // Fill with 1..16 then drain in order.
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'(i), 1'b0);
      cycle();
      check("fill.almostFull", 32'(almostFull), 32'(i >= 12));
    end
    check("fill.count", 32'(count), 32'd16);
    check("fill.pushReady", 32'(pushReady), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      check("drain.order", popData, 32'(i));
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      cycle();
    end
    check("drain.popValid", 32'(popValid), 32'd0);
    check("drain.count", 32'(count), 32'd0);

    // Single-word fall-through latency.
    drive(1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    cycle();
    check("fwft.popValid", 32'(popValid), 32'd1);
    check("fwft.popData", popData, 32'hDEADBEEF);
    check("fwft.almostEmpty", 32'(almostEmpty), 32'd1);
    do_reset();

    // Overflow: ignored write, sticky flag, head preserved; then full push+pop.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h100 + 32'(i), 1'b0);
      cycle();
    end
    drive(1'b1, 1'b0, 1'b1, 32'hBAD00000, 1'b0);
    cycle();
    check("ovf.count", 32'(count), 32'd16);
    check("ovf.flag", 32'(overflow), 32'd1);
    idle_cycle();
    check("ovf.sticky", 32'(overflow), 32'd1);
    check("ovf.head", popData, 32'h100);
    drive(1'b1, 1'b0, 1'b1, 32'hBAD00001, 1'b1);
    cycle();
    check("fullpp.count", 32'(count), 32'd15);
    check("fullpp.head", popData, 32'h101);
    do_reset();

    // Underflow then flush clears it.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle();
    check("udf.flag", 32'(underflow), 32'd1);
    check("udf.count", 32'(count), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    cycle();
    check("udf.flushed", 32'(underflow), 32'd0);

    // Steady state at 8 with simultaneous push/pop across pointer wrap.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'hC000 + 32'(i), 1'b0);
      cycle();
    end
    for (int i = 8; i < 48; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'hC000 + 32'(i), 1'b1);
      check("wrap.order", popData, 32'hC000 + 32'(i - 8));
      cycle();
    end
    check("wrap.count", 32'(count), 32'd8);

    // Reset overrides flush, push and pop.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'hE0 + 32'(i), 1'b0);
      cycle();
    end
    drive(1'b0, 1'b1, 1'b1, 32'hEEEE, 1'b1);
    cycle();
    check("rstov.count", 32'(count), 32'd0);
    check("rstov.popValid", 32'(popValid), 32'd0);
    check("rstov.pushReady", 32'(pushReady), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 299) != 0), ($urandom_range(0, 79) == 0),
            ($urandom_range(0, 99) < 55), $urandom(), ($urandom_range(0, 99) < 45));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
    $finish;
  end

endmodule
